// File: rtl/clock_time_set.sv
// ---------------------------------------------------------------------------
// clock_time_set
//
// Time-keeping and time-setting core for the digital clock. Keeps
// hours/minutes/seconds in packed BCD and lets the user edit hours and
// minutes through a three-state mode machine (RUN -> SET_HOUR -> SET_MIN).
// All outputs are registered and drive the seven-segment display directly.
//
// Parameters
//   RESET_HOUR  hour loaded on reset   (0-23)
//   RESET_MIN   minute loaded on reset (0-59)
//
// Ports
//   clk_sys   in   system clock
//   rstn      in   asynchronous, active-low reset
//   btn_mode  in   one-cycle pulse: advance mode
//   btn_inc   in   one-cycle pulse: increment edited field
//   btn_dec   in   one-cycle pulse: decrement edited field
//   tick_1hz  in   one-cycle pulse, once per second
//   hour_bcd  out  hours   {tens, ones}, 00-23
//   min_bcd   out  minutes {tens, ones}, 00-59
//   sec_bcd   out  seconds {tens, ones}, 00-59
//   mode      out  0 RUN, 1 SET_HOUR, 2 SET_MIN
//   blink_on  out  1 = edited field visible, 0 = display blanks it
// ---------------------------------------------------------------------------
module clock_time_set #(
    parameter int unsigned RESET_HOUR = 12,
    parameter int unsigned RESET_MIN  = 0
) (
    input  logic       clk_sys,
    input  logic       rstn,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       tick_1hz,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       blink_on
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SET_HOUR = 2'd1;
    localparam logic [1:0] ST_SET_MIN  = 2'd2;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] SEXA_MAX = 8'h59;

    localparam logic [7:0] RST_HOUR_BCD = 8'(((RESET_HOUR / 10) << 4) + (RESET_HOUR % 10));
    localparam logic [7:0] RST_MIN_BCD  = 8'(((RESET_MIN  / 10) << 4) + (RESET_MIN  % 10));

    logic [7:0] hour_q, hour_d;
    logic [7:0] min_q,  min_d;
    logic [7:0] sec_q,  sec_d;
    logic [1:0] mode_q, mode_d;
    logic       blink_q, blink_d;

    logic       edit_up;
    logic       edit_dn;

    // One BCD step with wrap-around. maxv is the top legal value of the
    // field (8'h23 or 8'h59); ones always roll at 9, so the only special
    // case beyond digit carry/borrow is the wrap at maxv / 00.
    function automatic logic [7:0] bcd_step(
        input logic [7:0] v,
        input logic       up,
        input logic [7:0] maxv
    );
        logic [3:0] tens;
        logic [3:0] ones;
        logic [7:0] res;
        tens = v[7:4];
        ones = v[3:0];
        if (up) begin
            if (v == maxv) begin
                res = '0;
            end else if (ones == 4'd9) begin
                res = {tens + 4'd1, 4'd0};
            end else begin
                res = {tens, ones + 4'd1};
            end
        end else begin
            if (v == 8'h00) begin
                res = maxv;
            end else if (ones == 4'd0) begin
                res = {tens - 4'd1, 4'd9};
            end else begin
                res = {tens, ones - 4'd1};
            end
        end
        return res;
    endfunction

    // A mode press discards any edit in the same cycle, and opposing
    // inc/dec presses cancel each other.
    assign edit_up = btn_inc & ~btn_dec & ~btn_mode;
    assign edit_dn = btn_dec & ~btn_inc & ~btn_mode;

    always_comb begin
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        mode_d  = mode_q;
        blink_d = blink_q;

        case (mode_q)
            ST_RUN: begin
                // Tick is applied even when btn_mode arrives with it.
                if (tick_1hz) begin
                    sec_d = bcd_step(sec_q, 1'b1, SEXA_MAX);
                    if (sec_q == SEXA_MAX) begin
                        min_d = bcd_step(min_q, 1'b1, SEXA_MAX);
                        if (min_q == SEXA_MAX) begin
                            hour_d = bcd_step(hour_q, 1'b1, HOUR_MAX);
                        end
                    end
                end
                if (btn_mode) begin
                    mode_d = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR: begin
                if (edit_up) begin
                    hour_d = bcd_step(hour_q, 1'b1, HOUR_MAX);
                end else if (edit_dn) begin
                    hour_d = bcd_step(hour_q, 1'b0, HOUR_MAX);
                end
                if (btn_mode) begin
                    mode_d = ST_SET_MIN;
                end
            end
            ST_SET_MIN: begin
                if (edit_up) begin
                    min_d = bcd_step(min_q, 1'b1, SEXA_MAX);
                end else if (edit_dn) begin
                    min_d = bcd_step(min_q, 1'b0, SEXA_MAX);
                end
                if (btn_mode) begin
                    mode_d = ST_RUN;
                    sec_d  = '0;
                end
            end
            default: begin
                mode_d = ST_RUN;
            end
        endcase

        // Visible constantly in RUN and on entry to a SET state; otherwise
        // the edited field flashes at the tick rate.
        if (mode_d == ST_RUN || mode_d != mode_q) begin
            blink_d = 1'b1;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            hour_q  <= RST_HOUR_BCD;
            min_q   <= RST_MIN_BCD;
            sec_q   <= '0;
            mode_q  <= ST_RUN;
            blink_q <= 1'b1;
        end else begin
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            mode_q  <= mode_d;
            blink_q <= blink_d;
        end
    end

    assign hour_bcd = hour_q;
    assign min_bcd  = min_q;
    assign sec_bcd  = sec_q;
    assign mode     = mode_q;
    assign blink_on = blink_q;

endmodule

// File: tb/tb_clock_time_set.sv
// ---------------------------------------------------------------------------
// tb_clock_time_set
//
// Bench for clock_time_set with default parameters (reset 12:00:00).
// Stimulus is driven on the falling edge; the expected outputs for each
// cycle are queued at drive time and popped 1 ns after the following rising
// edge. Expected values come either from a hand-written vector table or from
// an integer hour/minute/second model of the clock.
// ---------------------------------------------------------------------------
module tb_clock_time_set;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] md;
        logic       bl;
    } outs_t;

    // in = {btn_mode, btn_inc, btn_dec, tick_1hz}
    typedef struct {
        logic [3:0] in;
        outs_t      exp;
        string      name;
    } vec_t;

    logic       clk_sys;
    logic       rstn;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic       tick_1hz;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [1:0] mode;
    logic       blink_on;

    int unsigned n_tests;
    int unsigned n_fail;

    outs_t exp_q[$];

    // Integer reference model
    int m_h, m_m, m_s, m_md;
    logic m_bl;

    clock_time_set #(
        .RESET_HOUR(12),
        .RESET_MIN (0)
    ) dut (
        .clk_sys (clk_sys),
        .rstn    (rstn),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .btn_dec (btn_dec),
        .tick_1hz(tick_1hz),
        .hour_bcd(hour_bcd),
        .min_bcd (min_bcd),
        .sec_bcd (sec_bcd),
        .mode    (mode),
        .blink_on(blink_on)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        o.h  = to_bcd(m_h);
        o.m  = to_bcd(m_m);
        o.s  = to_bcd(m_s);
        o.md = 2'(m_md);
        o.bl = m_bl;
        return o;
    endfunction

    task automatic model_reset();
        m_h = 12; m_m = 0; m_s = 0; m_md = 0; m_bl = 1'b1;
    endtask

    task automatic model_step(input logic [3:0] in);
        logic bm, bi, bd, tk;
        int   nmd;
        {bm, bi, bd, tk} = in;
        nmd = bm ? (m_md + 1) % 3 : m_md;
        if (m_md == 0) begin
            if (tk) begin
                m_s = m_s + 1;
                if (m_s == 60) begin
                    m_s = 0;
                    m_m = m_m + 1;
                    if (m_m == 60) begin
                        m_m = 0;
                        m_h = (m_h + 1) % 24;
                    end
                end
            end
        end else if (m_md == 1) begin
            if (!bm && bi && !bd) m_h = (m_h + 1) % 24;
            if (!bm && bd && !bi) m_h = (m_h + 23) % 24;
        end else begin
            if (!bm && bi && !bd) m_m = (m_m + 1) % 60;
            if (!bm && bd && !bi) m_m = (m_m + 59) % 60;
            if (bm) m_s = 0;
        end
        if (nmd == 0 || nmd != m_md) m_bl = 1'b1;
        else if (tk) m_bl = ~m_bl;
        m_md = nmd;
    endtask

    task automatic compare(input string name, input outs_t exp);
        outs_t act;
        act = '{h: hour_bcd, m: min_bcd, s: sec_bcd, md: mode, bl: blink_on};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h:%h:%h mode=%0d blink=%b, expected %h:%h:%h mode=%0d blink=%b",
                     name, act.h, act.m, act.s, act.md, act.bl,
                     exp.h, exp.m, exp.s, exp.md, exp.bl);
        end
    endtask

    // One clock of stimulus. With use_tab the table value is the expectation;
    // the model is stepped either way so later model-driven checks stay valid.
    task automatic step(input logic [3:0] in, input logic use_tab,
                        input outs_t tab, input string name);
        outs_t e;
        @(negedge clk_sys);
        {btn_mode, btn_inc, btn_dec, tick_1hz} = in;
        model_step(in);
        e = use_tab ? tab : model_outs();
        exp_q.push_back(e);
        @(posedge clk_sys);
        #1;
        {btn_mode, btn_inc, btn_dec, tick_1hz} = 4'b0000;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            compare(name, exp_q.pop_front());
        end
    endtask

    localparam logic [3:0] I_MODE = 4'b1000;
    localparam logic [3:0] I_INC  = 4'b0100;
    localparam logic [3:0] I_DEC  = 4'b0010;
    localparam logic [3:0] I_TICK = 4'b0001;

    vec_t tab[15];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn = 1'b0;
        {btn_mode, btn_inc, btn_dec, tick_1hz} = 4'b0000;
        model_reset();

        // Starts from 00:00:00 in RUN with blink on.
        tab[0]  = '{I_MODE,         '{8'h00, 8'h00, 8'h00, 2'd1, 1'b1}, "enter_set_hour"};
        tab[1]  = '{I_DEC,          '{8'h23, 8'h00, 8'h00, 2'd1, 1'b1}, "hour_dec_wrap"};
        tab[2]  = '{I_INC,          '{8'h00, 8'h00, 8'h00, 2'd1, 1'b1}, "hour_inc_wrap"};
        tab[3]  = '{I_TICK,         '{8'h00, 8'h00, 8'h00, 2'd1, 1'b0}, "blink_tick1"};
        tab[4]  = '{I_TICK,         '{8'h00, 8'h00, 8'h00, 2'd1, 1'b1}, "blink_tick2"};
        tab[5]  = '{I_TICK,         '{8'h00, 8'h00, 8'h00, 2'd1, 1'b0}, "blink_tick3"};
        tab[6]  = '{I_INC | I_DEC,  '{8'h00, 8'h00, 8'h00, 2'd1, 1'b0}, "inc_dec_cancel_h"};
        tab[7]  = '{I_INC | I_TICK, '{8'h01, 8'h00, 8'h00, 2'd1, 1'b1}, "edit_with_tick"};
        tab[8]  = '{I_DEC,          '{8'h00, 8'h00, 8'h00, 2'd1, 1'b1}, "hour_dec"};
        tab[9]  = '{I_MODE | I_INC, '{8'h00, 8'h00, 8'h00, 2'd2, 1'b1}, "mode_beats_inc"};
        tab[10] = '{I_DEC,          '{8'h00, 8'h59, 8'h00, 2'd2, 1'b1}, "min_dec_wrap"};
        tab[11] = '{I_INC,          '{8'h00, 8'h00, 8'h00, 2'd2, 1'b1}, "min_inc_wrap"};
        tab[12] = '{I_INC | I_DEC,  '{8'h00, 8'h00, 8'h00, 2'd2, 1'b1}, "inc_dec_cancel_m"};
        tab[13] = '{I_DEC | I_TICK, '{8'h00, 8'h59, 8'h00, 2'd2, 1'b0}, "min_dec_tick"};
        tab[14] = '{I_INC,          '{8'h00, 8'h00, 8'h00, 2'd2, 1'b0}, "min_inc_no_hour"};

        // Reset state
        @(posedge clk_sys);
        #1;
        compare("reset_state", '{8'h12, 8'h00, 8'h00, 2'd0, 1'b1});
        @(negedge clk_sys);
        rstn = 1'b1;

        // 61 ticks -> 12:01:01
        for (int i = 0; i < 61; i++) step(I_TICK, 1'b0, '0, "run_tick");
        compare("run_61_ticks", '{8'h12, 8'h01, 8'h01, 2'd0, 1'b1});

        // Idle cycle and ignored edit in RUN
        step(I_INC, 1'b0, '0, "run_ignores_inc");

        // Preload 23:59 through the SET states
        step(I_MODE, 1'b0, '0, "to_set_hour");
        for (int i = 0; i < 11; i++) step(I_INC, 1'b0, '0, "hour_inc");
        step(I_MODE, 1'b0, '0, "to_set_min");
        step(I_DEC, 1'b0, '0, "min_dec");
        step(I_DEC, 1'b0, '0, "min_dec");
        step(I_MODE, 1'b1, '{8'h23, 8'h59, 8'h00, 2'd0, 1'b1}, "back_to_run_sec_clr");
        for (int i = 0; i < 59; i++) step(I_TICK, 1'b0, '0, "run_tick2");
        compare("at_23_59_59", '{8'h23, 8'h59, 8'h59, 2'd0, 1'b1});
        step(I_TICK, 1'b1, '{8'h00, 8'h00, 8'h00, 2'd0, 1'b1}, "full_rollover");

        // Table-driven corner cases
        for (int i = 0; i < 15; i++) step(tab[i].in, 1'b1, tab[i].exp, tab[i].name);

        // Minute 10 -> 09 borrow
        for (int i = 0; i < 10; i++) step(I_INC, 1'b0, '0, "min_inc");
        step(I_DEC, 1'b1, '{8'h00, 8'h09, 8'h00, 2'd2, 1'b0}, "min_10_to_09");

        // Back to RUN, then mode press together with a tick
        step(I_MODE, 1'b1, '{8'h00, 8'h09, 8'h00, 2'd0, 1'b1}, "set_min_to_run");
        step(I_TICK, 1'b0, '0, "resume_tick");
        step(I_MODE | I_TICK, 1'b1, '{8'h00, 8'h09, 8'h02, 2'd1, 1'b1}, "mode_with_tick");
        step(I_INC, 1'b0, '0, "hour_inc2");
        step(I_MODE, 1'b0, '0, "to_set_min2");
        step(I_INC, 1'b1, '{8'h01, 8'h10, 8'h02, 2'd2, 1'b1}, "min_edit_pre_reset");

        // Asynchronous reset mid-edit, checked before any clock edge
        @(negedge clk_sys);
        #2;
        rstn = 1'b0;
        #1;
        compare("async_reset", '{8'h12, 8'h00, 8'h00, 2'd0, 1'b1});
        model_reset();
        @(negedge clk_sys);
        rstn = 1'b1;
        step(I_TICK, 1'b1, '{8'h12, 8'h00, 8'h01, 2'd0, 1'b1}, "tick_after_reset");
        step(I_MODE, 1'b0, '0, "post_reset_mode");

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
